// File: rtl/disp_arbiter.sv
// rtl/disp_arbiter.sv - round-robin owner selection for the shared 8-digit display path
//
// Shares one seven-segment scan unit between three requesters. An owner keeps
// the display for at least HOLD_CYC cycles unless it drops its request first.
// Non-BCD nibbles are zeroed before they reach the scan unit.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   req[2:0]    level-sensitive request per source
//   data0..2    packed-BCD words per source, digit7 in [31:28]
//   grant[2:0]  one-hot current owner, zero when idle
//   display     sanitised word of the current owner, zero when idle
//   display_en  high whenever an owner exists
//   bad_digit   high while the driven word had a raw nibble above 9
module disp_arbiter #(
    parameter int HOLD_CYC = 100_000_000,
    parameter int CNT_W    = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic [2:0]  grant,
    output logic [31:0] display,
    output logic        display_en,
    output logic        bad_digit
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       grant_d;
    logic [31:0]      display_d;
    logic             en_d, bad_d;
    logic [2:0]       others;
    logic             expired;
    logic [31:0]      sel_data;

    // First set bit of mask searching base+1, base+2, base+3 (mod 3).
    // Walking the offsets downwards lets the nearest candidate win.
    function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [2:0] mask);
        logic [1:0] idx;
        rr_pick = base;
        for (int i = 3; i >= 1; i--) begin
            idx = 2'((int'(base) + i) % 3);
            if (mask[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] k);
        onehot = 3'b001 << k;
    endfunction

    function automatic logic [31:0] sanitise(input logic [31:0] w);
        for (int i = 0; i < 8; i++) begin
            sanitise[4*i +: 4] = (w[4*i +: 4] > 4'd9) ? 4'd0 : w[4*i +: 4];
        end
    endfunction

    function automatic logic has_bad(input logic [31:0] w);
        has_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (w[4*i +: 4] > 4'd9) has_bad = 1'b1;
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 2'd0;
            last_q     <= 2'd2;
            cnt_q      <= '0;
            grant      <= 3'b000;
            display    <= 32'h0;
            display_en <= 1'b0;
            bad_digit  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            grant      <= grant_d;
            display    <= display_d;
            display_en <= en_d;
            bad_digit  <= bad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        others  = req & ~onehot(owner_q);
        expired = (cnt_q == CNT_MAX);

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = OWN;
                    owner_d = rr_pick(last_q, req);
                    cnt_d   = '0;
                end
            end
            OWN: begin
                if (!req[owner_q]) begin
                    // Release wins over expiry; the owner leaves regardless of the hold.
                    last_d = owner_q;
                    cnt_d  = '0;
                    if (|others) owner_d = rr_pick(owner_q, others);
                    else         state_d = IDLE;
                end else if (expired && |others) begin
                    last_d  = owner_q;
                    owner_d = rr_pick(owner_q, others);
                    cnt_d   = '0;
                end else if (!expired) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next owner so grant and display move together.
        case (owner_d)
            2'd1:    sel_data = data1;
            2'd2:    sel_data = data2;
            default: sel_data = data0;
        endcase

        grant_d   = 3'b000;
        display_d = 32'h0;
        en_d      = 1'b0;
        bad_d     = 1'b0;
        if (state_d == OWN) begin
            grant_d   = onehot(owner_d);
            display_d = sanitise(sel_data);
            en_d      = 1'b1;
            bad_d     = has_bad(sel_data);
        end
    end

endmodule

// File: tb/tb_disp_arbiter.sv
// tb/tb_disp_arbiter.sv - directed self-checking bench for disp_arbiter
module tb_disp_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [31:0] data0 = 32'h0;
    logic [31:0] data1 = 32'h0;
    logic [31:0] data2 = 32'h0;
    logic [2:0]  grant;
    logic [31:0] display;
    logic        display_en;
    logic        bad_digit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    disp_arbiter #(.HOLD_CYC(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data0      (data0),
        .data1      (data1),
        .data2      (data2),
        .grant      (grant),
        .display    (display),
        .display_en (display_en),
        .bad_digit  (bad_digit)
    );

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        data1 = 32'h1234_5678;
        req   = 3'b010;
        @(negedge clk);
        checks++;
        if (grant !== 3'b010) begin
            errors++; $display("FAIL reset_pre_grant: got %b want 010", grant);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (grant !== 3'b000 || display !== 32'h0 || display_en !== 1'b0 || bad_digit !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: grant=%b display=%h en=%b bad=%b want 000/0/0/0",
                     grant, display, display_en, bad_digit);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 3'b111;
        @(negedge clk);
        checks++;
        if (grant !== 3'b001) begin
            errors++; $display("FAIL reset_first_priority: got %b want 001", grant);
        end
    endtask

    task automatic test_basic_grant();
        do_reset();
        checks++;
        if (grant !== 3'b000 || display_en !== 1'b0 || display !== 32'h0) begin
            errors++; $display("FAIL idle_state: grant=%b en=%b display=%h", grant, display_en, display);
        end
        data2 = 32'h1234_5678;
        req   = 3'b100;
        @(negedge clk);
        checks++;
        if (grant !== 3'b100 || display_en !== 1'b1 || display !== 32'h1234_5678 || bad_digit !== 1'b0) begin
            errors++;
            $display("FAIL basic_grant: grant=%b en=%b display=%h bad=%b want 100/1/12345678/0",
                     grant, display_en, display, bad_digit);
        end
        data2 = 32'h0000_0009;
        @(negedge clk);
        checks++;
        if (display !== 32'h0000_0009) begin
            errors++; $display("FAIL basic_follow: got %h want 00000009", display);
        end
    endtask

    task automatic test_rotation();
        logic [2:0]  exp_g;
        logic [31:0] exp_d;
        data0 = 32'h1111_1111;
        data1 = 32'h2222_2222;
        data2 = 32'h3333_3333;
        do_reset();
        req = 3'b111;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            case ((i / 4) % 3)
                0:       begin exp_g = 3'b001; exp_d = 32'h1111_1111; end
                1:       begin exp_g = 3'b010; exp_d = 32'h2222_2222; end
                default: begin exp_g = 3'b100; exp_d = 32'h3333_3333; end
            endcase
            checks++;
            if (grant !== exp_g || display !== exp_d || display_en !== 1'b1) begin
                errors++;
                $display("FAIL rotation[%0d]: grant=%b display=%h en=%b want %b/%h/1",
                         i, grant, display, display_en, exp_g, exp_d);
            end
        end
    endtask

    task automatic test_early_release();
        data0 = 32'h0000_0010;
        data1 = 32'h0000_0020;
        do_reset();
        req = 3'b011;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (grant !== 3'b001) begin
                errors++; $display("FAIL release_owner0[%0d]: got %b want 001", i, grant);
            end
        end
        req = 3'b010;
        @(negedge clk);
        checks++;
        if (grant !== 3'b010 || display !== 32'h0000_0020) begin
            errors++; $display("FAIL release_switch: grant=%b display=%h want 010/00000020", grant, display);
        end
        // Contender returns: owner 1 must still hold a full 4 cycles from its fresh counter.
        req = 3'b011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (grant !== 3'b010) begin
                errors++; $display("FAIL release_restart[%0d]: got %b want 010", i, grant);
            end
        end
        @(negedge clk);
        checks++;
        if (grant !== 3'b001) begin
            errors++; $display("FAIL release_preempt: got %b want 001", grant);
        end
        req = 3'b010;
        @(negedge clk);
        checks++;
        if (grant !== 3'b010) begin
            errors++; $display("FAIL release_to_1: got %b want 010", grant);
        end
        req = 3'b000;
        @(negedge clk);
        checks++;
        if (grant !== 3'b000 || display !== 32'h0 || display_en !== 1'b0 || bad_digit !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: grant=%b display=%h en=%b bad=%b want 000/0/0/0",
                     grant, display, display_en, bad_digit);
        end
    endtask

    task automatic test_saturation();
        data0 = 32'h0000_0001;
        data2 = 32'h0000_0002;
        do_reset();
        req = 3'b001;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (grant !== 3'b001) begin
                errors++; $display("FAIL saturate[%0d]: got %b want 001", i, grant);
            end
        end
        req = 3'b101;
        @(negedge clk);
        checks++;
        if (grant !== 3'b100 || display !== 32'h0000_0002) begin
            errors++; $display("FAIL late_arrival: grant=%b display=%h want 100/00000002", grant, display);
        end
    endtask

    task automatic test_sanitise();
        data0 = 32'hA1B2_0003;
        do_reset();
        req = 3'b001;
        @(negedge clk);
        checks++;
        if (display !== 32'h0102_0003 || bad_digit !== 1'b1) begin
            errors++; $display("FAIL sanitise_bad: display=%h bad=%b want 01020003/1", display, bad_digit);
        end
        data0 = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (display !== 32'h0 || bad_digit !== 1'b1) begin
            errors++; $display("FAIL sanitise_all: display=%h bad=%b want 00000000/1", display, bad_digit);
        end
        data0 = 32'h0000_0003;
        @(negedge clk);
        checks++;
        if (display !== 32'h0000_0003 || bad_digit !== 1'b0) begin
            errors++; $display("FAIL sanitise_clean: display=%h bad=%b want 00000003/0", display, bad_digit);
        end
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_rotation();
        test_early_release();
        test_saturation();
        test_sanitise();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
